// File: rtl/mvm_param.sv
// mvm_param: streaming signed matrix-vector multiply-accumulate, y = W*x + b.
//
// One job is a stream of signed DW-bit words on the input channel. In load
// mode it is W (row-major, N*N words), then b (N words), then x (N words).
// In reuse mode it is x only, and the stored W and b are used. The N results
// leave one per handshake on the output channel, y[0] first.
//
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   s_valid   input word valid
//   s_ready   block accepts the input word this cycle
//   data_in   input word (W, b or x element), DW bits
//   load_w    mode select, sampled on the first accepted word of a job
//   m_valid   data_out holds a result
//   m_ready   sink accepts the result
//   data_out  signed result y[i], OW bits
//   state     current FSM state (debug observation)
//
// Handshake rule (both channels): a word moves on a rising edge where
// valid && ready are both high. The source may hold valid low for any number
// of cycles without losing data. While m_valid && !m_ready the output word
// and all internal state are frozen.
//
// Build option: define MVM_RELU_EN to clamp negative results to zero.

module mvm_param #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] data_in,
  input  logic          load_w,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] data_out,
  output logic [2:0]    state
);

  localparam int WA = $clog2(N * N);
  localparam int XA = $clog2(N);
  localparam int KA = $clog2(N + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_W = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] LOAD_X = 3'd3;
  localparam logic [2:0] MAC    = 3'd4;
  localparam logic [2:0] OUT    = 3'd5;

  localparam logic [WA-1:0] W_LAST = WA'(N * N - 1);
  localparam logic [XA-1:0] V_LAST = XA'(N - 1);
  localparam logic [KA-1:0] K_LAST = KA'(N);
  localparam logic [KA-1:0] K_ONE  = KA'(1);

  logic [WA-1:0] w_cnt;
  logic [XA-1:0] b_cnt;
  logic [XA-1:0] x_cnt;
  logic [XA-1:0] row;
  logic [KA-1:0] k;
  logic          w_loaded;
  logic signed [OW-1:0] acc;

  logic signed [DW-1:0] w_mem [N*N];
  logic signed [DW-1:0] b_mem [N];
  logic signed [DW-1:0] x_mem [N];
  logic signed [DW-1:0] w_q;
  logic signed [DW-1:0] b_q;
  logic signed [DW-1:0] x_q;

  logic          xfer;
  logic          load_mode;
  logic [XA-1:0] k_rd;
  logic [WA-1:0] w_addr;
  logic [XA-1:0] b_addr;
  logic [XA-1:0] x_addr;
  logic          w_we;
  logic          b_we;
  logic          x_we;

  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0]   prod_ext;
  logic signed [OW-1:0]   b_ext;
  logic signed [OW-1:0]   sum;
  logic signed [OW-1:0]   result;

  assign s_ready = reset_n && (state == IDLE || state == LOAD_W ||
                               state == LOAD_B || state == LOAD_X);
  assign m_valid = (state == OUT);

  assign xfer      = s_valid && s_ready;
  // Reuse is only honoured once a complete W/b set has been stored.
  assign load_mode = load_w || !w_loaded;

  // MAC column k issues reads for column k; step k == N only drains the
  // pipeline, so its read address is parked on a valid entry.
  assign k_rd   = (k == K_LAST) ? V_LAST : k[XA-1:0];
  assign w_addr = (state == MAC) ? (WA'(row) * WA'(N) + WA'(k_rd)) : w_cnt;
  assign b_addr = (state == LOAD_B) ? b_cnt : row;
  assign x_addr = (state == MAC) ? k_rd : x_cnt;

  assign w_we = xfer && (state == LOAD_W || (state == IDLE && load_mode));
  assign b_we = xfer && (state == LOAD_B);
  assign x_we = xfer && (state == LOAD_X || (state == IDLE && !load_mode));

  // Single-port RAMs with one-cycle registered read.
  always_ff @(posedge clk) begin
    if (w_we) w_mem[w_addr] <= data_in;
    w_q <= w_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (b_we) b_mem[b_addr] <= data_in;
    b_q <= b_mem[b_addr];
  end

  always_ff @(posedge clk) begin
    if (x_we) x_mem[x_addr] <= data_in;
    x_q <= x_mem[x_addr];
  end

  // Read data for column k-1 arrives while k is current; the bias of the row
  // seeds the sum on the first product.
  assign prod     = w_q * x_q;
  assign prod_ext = OW'(prod);
  assign b_ext    = OW'(b_q);
  assign sum      = ((k == K_ONE) ? b_ext : acc) + prod_ext;

`ifdef MVM_RELU_EN
  assign result = sum[OW-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      w_cnt    <= '0;
      b_cnt    <= '0;
      x_cnt    <= '0;
      row      <= '0;
      k        <= '0;
      w_loaded <= 1'b0;
      acc      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            // The first word is stored at index 0 of whichever phase starts.
            if (load_mode) begin
              w_cnt <= WA'(1);
              state <= LOAD_W;
            end else begin
              x_cnt <= XA'(1);
              state <= LOAD_X;
            end
          end
        end
        LOAD_W: begin
          if (xfer) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              b_cnt <= '0;
              state <= LOAD_B;
            end else begin
              w_cnt <= w_cnt + WA'(1);
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            if (b_cnt == V_LAST) begin
              b_cnt    <= '0;
              x_cnt    <= '0;
              w_loaded <= 1'b1;
              state    <= LOAD_X;
            end else begin
              b_cnt <= b_cnt + XA'(1);
            end
          end
        end
        LOAD_X: begin
          if (xfer) begin
            if (x_cnt == V_LAST) begin
              x_cnt <= '0;
              row   <= '0;
              k     <= '0;
              state <= MAC;
            end else begin
              x_cnt <= x_cnt + XA'(1);
            end
          end
        end
        MAC: begin
          if (k != '0) acc <= sum;
          if (k == K_LAST) begin
            data_out <= result;
            state    <= OUT;
          end else begin
            k <= k + KA'(1);
          end
        end
        OUT: begin
          if (m_ready) begin
            k <= '0;
            if (row == V_LAST) begin
              row   <= '0;
              state <= IDLE;
            end else begin
              row   <= row + XA'(1);
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
